// File: rtl/vector_mac_stream_if.sv
// Beat-in / result-out bundle of the streaming dot-product unit.
// The driver of the bus uses master; the MAC core uses slave.
interface vector_mac_stream_if #(
  parameter int LANES          = 8,
  parameter int FEATURE_WIDTH  = 5,
  parameter int WEIGHT_WIDTH   = 5,
  parameter int DOT_PROD_WIDTH = 16
);
  logic                                    clear;
  logic                                    signed_mode;
  logic                                    in_valid;
  logic                                    in_ready;
  logic [LANES-1:0][FEATURE_WIDTH-1:0]     in_feature;
  logic [LANES-1:0][WEIGHT_WIDTH-1:0]      in_weight;
  logic                                    out_valid;
  logic                                    out_ready;
  logic [DOT_PROD_WIDTH-1:0]               dot_product;
  logic                                    overflow;
  logic                                    busy;

  modport master (
    output clear, signed_mode, in_valid, in_feature, in_weight, out_ready,
    input  in_ready, out_valid, dot_product, overflow, busy
  );

  modport slave (
    input  clear, signed_mode, in_valid, in_feature, in_weight, out_ready,
    output in_ready, out_valid, dot_product, overflow, busy
  );
endinterface

// File: rtl/vector_mac_stream.sv
// Streaming row-by-column dot product: LANES products per beat, two-stage
// pipeline (lane sum, then accumulate), saturated result with overflow flag.
module vector_mac_stream #(
  parameter int FEATURE_COLS   = 96,
  parameter int FEATURE_WIDTH  = 5,
  parameter int WEIGHT_WIDTH   = 5,
  parameter int LANES          = 8,
  parameter int DOT_PROD_WIDTH = 16
) (
  input logic                  clk,
  input logic                  reset,
  vector_mac_stream_if.slave   bus
);

  localparam int BEATS  = (FEATURE_COLS + LANES - 1) / LANES;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ACC_W  = FEATURE_WIDTH + WEIGHT_WIDTH + $clog2(FEATURE_COLS) + 1;
  localparam int PROD_W = FEATURE_WIDTH + WEIGHT_WIDTH + 2;
  localparam int EXT_W  = ACC_W + DOT_PROD_WIDTH + 1;

  localparam logic [CNT_W-1:0]        LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic signed [EXT_W-1:0] U_MAX = EXT_W'((64'sd1 <<< DOT_PROD_WIDTH) - 64'sd1);
  localparam logic signed [EXT_W-1:0] S_MAX = EXT_W'((64'sd1 <<< (DOT_PROD_WIDTH - 1)) - 64'sd1);
  localparam logic signed [EXT_W-1:0] S_MIN = ~S_MAX;

  typedef enum logic {ST_ACCEPT, ST_DRAIN} state_e;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           beat_cnt;
  logic                       mode_q;
  logic                       s1_valid, s1_first, s1_last;
  logic signed [ACC_W-1:0]    s1_sum, acc;
  logic                       out_valid_q, ovf_q;
  logic [DOT_PROD_WIDTH-1:0]  dp_q;

  logic                       accept, beat_mode, first_beat, last_beat;
  logic signed [ACC_W-1:0]    beat_sum;
  logic signed [EXT_W-1:0]    total;
  logic [DOT_PROD_WIDTH-1:0]  sat_val;
  logic                       sat_ovf;

  // clear wins over a beat offered in the same cycle
  assign accept     = bus.in_valid && (state_q == ST_ACCEPT) && !bus.clear;
  assign first_beat = (beat_cnt == '0);
  assign last_beat  = (beat_cnt == LAST_BEAT);
  assign beat_mode  = first_beat ? bus.signed_mode : mode_q;

  always_comb begin : lane_sum
    logic signed [FEATURE_WIDTH:0] f_ext;
    logic signed [WEIGHT_WIDTH:0]  w_ext;
    logic signed [PROD_W-1:0]      prod;
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    f_ext    = '0;
    w_ext    = '0;
    prod     = '0;
    beat_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      f_ext = {beat_mode & bus.in_feature[l][FEATURE_WIDTH-1], bus.in_feature[l]};
      w_ext = {beat_mode & bus.in_weight[l][WEIGHT_WIDTH-1], bus.in_weight[l]};
      prod  = f_ext * w_ext;
      if (int'(beat_cnt) * LANES + l < FEATURE_COLS)
        beat_sum = beat_sum + ACC_W'(prod);
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      ST_ACCEPT: if (accept && last_beat) state_d = ST_DRAIN;
      ST_DRAIN:  if (out_valid_q && bus.out_ready) state_d = ST_ACCEPT;
      default:   state_d = ST_ACCEPT;
    endcase
    if (bus.clear) state_d = ST_ACCEPT;
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state_q <= ST_ACCEPT;
    else       state_q <= state_d;
  end

  // Saturate the final sum in the mode latched on this vector's first beat.
  always_comb begin : saturate
    total   = s1_first ? EXT_W'(s1_sum) : EXT_W'(acc) + EXT_W'(s1_sum);
    sat_val = total[DOT_PROD_WIDTH-1:0];
    sat_ovf = 1'b0;
    if (mode_q) begin
      if (total > S_MAX) begin
        sat_val = S_MAX[DOT_PROD_WIDTH-1:0];
        sat_ovf = 1'b1;
      end else if (total < S_MIN) begin
        sat_val = S_MIN[DOT_PROD_WIDTH-1:0];
        sat_ovf = 1'b1;
      end
    end else if (total > U_MAX) begin
      sat_val = U_MAX[DOT_PROD_WIDTH-1:0];
      sat_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: datapath registers are reset as well; reset must leave no stale partial sum behind.
    if (reset) begin
      beat_cnt    <= '0;
      mode_q      <= 1'b0;
      s1_valid    <= 1'b0;
      s1_first    <= 1'b0;
      s1_last     <= 1'b0;
      s1_sum      <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      dp_q        <= '0;
      ovf_q       <= 1'b0;
    end else if (bus.clear) begin
      beat_cnt    <= '0;
      s1_valid    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        if (first_beat) mode_q <= bus.signed_mode;
        s1_first <= first_beat;
        s1_last  <= last_beat;
        s1_sum   <= beat_sum;
      end

      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;

      if (s1_valid) begin
        acc <= s1_first ? s1_sum : acc + s1_sum;
        if (s1_last) begin
          out_valid_q <= 1'b1;
          dp_q        <= sat_val;
          ovf_q       <= sat_ovf;
        end
      end
    end
  end

  assign bus.in_ready    = (state_q == ST_ACCEPT);
  assign bus.out_valid   = out_valid_q;
  assign bus.dot_product = dp_q;
  assign bus.overflow    = ovf_q;
  assign bus.busy        = (state_q == ST_DRAIN) || (beat_cnt != '0);

endmodule

// File: doc/vector_mac_stream.md
Name: vector_mac_stream

Overview:
- Sequential, parametrised successor to the combinational row·column dot-product unit.
- Accepts one feature row and one weight column as a stream of LANES-wide beats over a valid/ready handshake, and accumulates them through a two-stage pipeline.
- Emits one saturated dot product per vector, with an overflow flag.
- Sits between the feature/weight buffer readers and the aggregation stage of the GCN datapath. Trades area for throughput via LANES.

Parameters:
- FEATURE_COLS, 96, elements per vector.
- FEATURE_WIDTH, 5, bits per feature element.
- WEIGHT_WIDTH, 5, bits per weight element.
- LANES, 8, elements consumed per beat; 1 ≤ LANES ≤ FEATURE_COLS.
- DOT_PROD_WIDTH, 16, output width.

Ports:
- clk, input, 1, sole clock; rising edge.
- reset, input, 1, asynchronous, active-high; clears all state.
- clear, input, 1, synchronous abort of the vector in progress.
- signed_mode, input, 1, 1 = two's-complement operands and result; sampled on the first beat of each vector.
- in_valid, input, 1, beat valid.
- in_ready, output, 1, beat accepted when in_valid && in_ready.
- in_feature, input, LANES x FEATURE_WIDTH, feature chunk; lane l carries element beat*LANES+l.
- in_weight, input, LANES x WEIGHT_WIDTH, weight chunk; same indexing.
- out_valid, output, 1, result valid; held until accepted.
- out_ready, input, 1, result accepted when out_valid && out_ready.
- dot_product, output, DOT_PROD_WIDTH, saturated result.
- overflow, output, 1, result was clamped; qualified by out_valid.
- busy, output, 1, a vector is partially accumulated or a result is pending.

Behaviour:
- Derived constants:
  - BEATS = ceil(FEATURE_COLS/LANES).
  - ACC_W = FEATURE_WIDTH+WEIGHT_WIDTH+clog2(FEATURE_COLS)+1. The internal accumulator never wraps.
- Reset values: in_ready=1, out_valid=0, dot_product=0, overflow=0, busy=0. Beat counter, pipeline and accumulator are all 0.
- FSM states:
  - ACCEPT: in_ready=1.
  - DRAIN: in_ready=0; last beat is in the pipeline or a result is pending.
  - ACCEPT→DRAIN on acceptance of the beat with beat_cnt==BEATS-1.
  - DRAIN→ACCEPT in the cycle after the out_valid && out_ready handshake.
- beat_cnt counts 0..BEATS-1, advances only on an accepted beat, and wraps to 0 after the last beat.
- Masking: a lane whose index beat_cnt*LANES+l ≥ FEATURE_COLS contributes 0 whatever its input value.
- Stage 1, registered: sum of the LANES lane products of the accepted beat, plus first and last flags. Operands are sign-extended if the latched mode is signed, zero-extended otherwise.
- Stage 2, registered:
  - First beat: acc = p_sum.
  - Other beats: acc += p_sum.
  - Last beat: the result register is loaded and out_valid=1.
- Latency: last beat accepted at cycle t → out_valid=1 at t+2. Back-to-back beats reach full throughput (one beat/cycle); in_valid bubbles are allowed anywhere.
- Saturation:
  - Unsigned: clamp to 2^DOT_PROD_WIDTH-1.
  - Signed: clamp to [-2^(DOT_PROD_WIDTH-1), 2^(DOT_PROD_WIDTH-1)-1].
  - overflow=1 iff a clamp occurred.
- dot_product and overflow stay stable while out_valid && !out_ready. out_valid falls in the cycle after the handshake. dot_product keeps its last value after that.
- signed_mode changes mid-vector are ignored until the next first beat.
- clear:
  - Returns to ACCEPT with beat_cnt=0, empties the pipeline, drops out_valid, and discards any pending result.
  - clear overrides an in_valid asserted in the same cycle; that beat is not accepted.
- reset mid-vector: immediate return to reset values; the next accepted beat is treated as beat 0.
- busy=1 from the first accepted beat until the result handshake, or until clear/reset.

Test Plan:
- Defaults, unsigned, all features=1 and weights=1, 12 back-to-back beats → dot_product=96, overflow=0, out_valid exactly 2 cycles after the 12th acceptance.
- Defaults, unsigned, all 31×31 → true sum 92256 clamps to dot_product=65535, overflow=1.
- signed_mode=1, features=5'b11111 (-1), weights=2 → dot_product=16'hFF40 (-192), overflow=0. Toggling signed_mode to 0 mid-vector leaves the result unchanged.
- FEATURE_COLS=10, LANES=4, all ones with padding lanes of beat 2 driven to 31 → 3 beats, dot_product=10.
- Backpressure and bubbles:
  - out_ready held low 5 cycles → out_valid and dot_product stable, in_ready=0.
  - Release → in_ready=1 the cycle after the handshake.
  - Random in_valid gaps give the same result as the back-to-back case.
- Abort:
  - After 5 beats, pulse clear → busy=0, beat_cnt=0; the next full all-ones vector yields 96.
  - Repeat with reset asserted asynchronously mid-cycle → outputs go to reset values immediately; the next vector again yields 96.
